// File: rtl/display_scan.sv
// Four-digit multiplexed hex seven-segment driver with tear-free, frame-aligned value commit.
// Optional leading-zero blanking when DISPLAY_SCAN_BLANK_EN is defined.
module display_scan #(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    output logic        ack,
    output logic [6:0]  lcd,
    output logic [3:0]  digits
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          pend_v;
    logic          commit;

    logic          tick;
    logic          frame;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick  = (pcnt == PMAX);
    assign frame = tick && (idx == 2'd3);

    always_comb begin
        nib   = disp[{idx, 2'b00} +: 4];
        blank = 1'b0;
`ifdef DISPLAY_SCAN_BLANK_EN
        // A digit goes dark when it and every more-significant nibble are zero
        case (idx)
            2'd3:    blank = (disp[15:12] == 4'h0);
            2'd2:    blank = (disp[15:8] == 8'h00);
            2'd1:    blank = (disp[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        seg_next = blank ? 7'h7F : ~seg7(nib);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt   <= '0;
            idx    <= 2'd0;
            disp   <= 16'h0000;
            pend   <= 16'h0000;
            pend_v <= 1'b0;
            commit <= 1'b0;
            ack    <= 1'b0;
            lcd    <= 7'h7F;
            digits <= 4'b1111;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // Commit uses pend as it stood before this edge; a same-edge load waits a frame
            if (frame && pend_v) begin
                disp <= pend;
            end
            if (load) begin
                pend   <= value;
                pend_v <= 1'b1;
            end else if (frame) begin
                pend_v <= 1'b0;
            end

            // ack is delayed one cycle so it lines up with the first new digit 0 on lcd
            commit <= frame && pend_v;
            ack    <= commit;

            lcd    <= seg_next;
            digits <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed self-checking bench for display_scan at SCAN_DIV=4, plus a SCAN_DIV=1 instance.
module tb_display_scan;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        load1 = 1'b0;
    logic        ack, ack1;
    logic [6:0]  lcd, lcd1;
    logic [3:0]  digits, digits1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

`ifdef DISPLAY_SCAN_BLANK_EN
    localparam logic [6:0] ZHI = 7'h7F;
`else
    localparam logic [6:0] ZHI = 7'h40;
`endif

    display_scan #(.SCAN_DIV(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .ack     (ack),
        .lcd     (lcd),
        .digits  (digits)
    );

    display_scan #(.SCAN_DIV(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (value),
        .load    (load1),
        .ack     (ack1),
        .lcd     (lcd1),
        .digits  (digits1)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (lcd !== 7'h7F) begin n_fail++; $display("FAIL reset_lcd: got %h, expected 7f", lcd); end
        n_checks++;
        if (digits !== 4'b1111) begin n_fail++; $display("FAIL reset_digits: got %b, expected 1111", digits); end
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", ack); end
        n_checks++;
        if (lcd1 !== 7'h7F || digits1 !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_div1: got lcd %h digits %b, expected 7f 1111", lcd1, digits1);
        end
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        int d;
        logic [3:0] ed;
        while (cyc < 32) begin
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL scan_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== 7'h40) begin n_fail++; $display("FAIL scan_lcd cyc=%0d: got %h, expected 40", cyc, lcd); end
            n_checks++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL scan_ack cyc=%0d: got %b, expected 0", cyc, ack); end
            if (cyc <= 8) begin
                ed = ~(4'b0001 << ((cyc - 1) % 4));
                n_checks++;
                if (digits1 !== ed || lcd1 !== 7'h40 || ack1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan_div1 cyc=%0d: got %b/%h/%b, expected %b/40/0",
                             cyc, digits1, lcd1, ack1, ed);
                end
            end
        end
    endtask

    task automatic test_load();
        int d;
        logic [3:0] ed;
        logic [6:0] el;
        logic [6:0] eo [4];
        logic [6:0] en [4];
        eo = '{7'h40, 7'h40, 7'h40, 7'h40};
        en = '{7'h19, 7'h30, 7'h24, 7'h79};
        while (cyc < 64) begin
            if (cyc == 37) begin value = 16'h1234; load = 1'b1; end else load = 1'b0;
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            el = (cyc >= 49) ? en[d] : eo[d];
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL load_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== el) begin n_fail++; $display("FAIL load_lcd cyc=%0d: got %h, expected %h", cyc, lcd, el); end
            n_checks++;
            if (ack !== (cyc == 49)) begin n_fail++; $display("FAIL load_ack cyc=%0d: got %b, expected %b", cyc, ack, cyc == 49); end
        end
    endtask

    task automatic test_overwrite();
        int d;
        logic [3:0] ed;
        logic [6:0] el;
        logic [6:0] eo [4];
        logic [6:0] en [4];
        eo = '{7'h19, 7'h30, 7'h24, 7'h79};
        en = '{7'h21, 7'h46, 7'h03, 7'h08};
        while (cyc < 96) begin
            if (cyc == 65) begin value = 16'h1111; load = 1'b1; end
            else if (cyc == 69) begin value = 16'hABCD; load = 1'b1; end
            else load = 1'b0;
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            el = (cyc >= 81) ? en[d] : eo[d];
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL ovw_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== el) begin n_fail++; $display("FAIL ovw_lcd cyc=%0d: got %h, expected %h", cyc, lcd, el); end
            n_checks++;
            if (ack !== (cyc == 81)) begin n_fail++; $display("FAIL ovw_ack cyc=%0d: got %b, expected %b", cyc, ack, cyc == 81); end
        end
    endtask

    task automatic test_boundary_load();
        int d;
        logic [3:0] ed;
        logic [6:0] el;
        logic [6:0] eo [4];
        logic [6:0] en [4];
        eo = '{7'h21, 7'h46, 7'h03, 7'h08};
        en = '{7'h0E, 7'h0E, ZHI, ZHI};
        while (cyc < 144) begin
            if (cyc == 111) begin value = 16'h00FF; load = 1'b1; end else load = 1'b0;
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            el = (cyc >= 129) ? en[d] : eo[d];
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL bnd_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== el) begin n_fail++; $display("FAIL bnd_lcd cyc=%0d: got %h, expected %h", cyc, lcd, el); end
            n_checks++;
            if (ack !== (cyc == 129)) begin n_fail++; $display("FAIL bnd_ack cyc=%0d: got %b, expected %b", cyc, ack, cyc == 129); end
        end
    endtask

    task automatic test_reset_mid();
        int d;
        logic [3:0] ed;
        while (cyc < 152) begin
            if (cyc == 149) begin value = 16'h5555; load = 1'b1; end else load = 1'b0;
            step();
        end
        n_checks++;
        if (lcd !== 7'h0E) begin n_fail++; $display("FAIL rst_mid_pre_lcd: got %h, expected 0e", lcd); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (lcd !== 7'h7F || digits !== 4'b1111) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %h/%b, expected 7f/1111", lcd, digits);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (lcd !== 7'h7F || digits !== 4'b1111 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_held: got %h/%b/%b, expected 7f/1111/0", lcd, digits, ack);
        end
        reset_n = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL rst_mid_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== 7'h40) begin n_fail++; $display("FAIL rst_mid_lcd cyc=%0d: got %h, expected 40", cyc, lcd); end
            n_checks++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack cyc=%0d: got %b, expected 0", cyc, ack); end
        end
    endtask

    task automatic test_blank();
        int d;
        logic [3:0] ed;
        logic [6:0] el;
        logic [6:0] e0 [4];
        logic [6:0] e1 [4];
        logic [6:0] e2 [4];
        e0 = '{7'h40, 7'h40, 7'h40, 7'h40};
        e1 = '{7'h24, 7'h19, ZHI, ZHI};
        e2 = '{7'h40, ZHI, ZHI, ZHI};
        while (cyc < 96) begin
            if (cyc == 41) begin value = 16'h0042; load = 1'b1; end
            else if (cyc == 65) begin value = 16'h0000; load = 1'b1; end
            else load = 1'b0;
            step();
            d  = ((cyc - 1) / 4) % 4;
            ed = ~(4'b0001 << d);
            el = (cyc >= 81) ? e2[d] : (cyc >= 49) ? e1[d] : e0[d];
            n_checks++;
            if (digits !== ed) begin n_fail++; $display("FAIL blank_digits cyc=%0d: got %b, expected %b", cyc, digits, ed); end
            n_checks++;
            if (lcd !== el) begin n_fail++; $display("FAIL blank_lcd cyc=%0d: got %h, expected %h", cyc, lcd, el); end
            n_checks++;
            if (ack !== (cyc == 49 || cyc == 81)) begin
                n_fail++;
                $display("FAIL blank_ack cyc=%0d: got %b, expected %b", cyc, ack, cyc == 49 || cyc == 81);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_overwrite();
        test_boundary_load();
        test_reset_mid();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
